// File: rtl/memory_pkg.sv
// Shared frame-buffer constants: screen geometry, colour codes and address helpers.
package memory_pkg;

  localparam int unsigned PX_WIDTH  = 160;
  localparam int unsigned PX_HEIGHT = 120;
  localparam int unsigned DEPTH     = PX_WIDTH * PX_HEIGHT;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 3;
  localparam int unsigned IDX_W     = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  localparam logic [DATA_W-1:0] COL_BLACK   = 3'd0;
  localparam logic [DATA_W-1:0] COL_BLUE    = 3'd1;
  localparam logic [DATA_W-1:0] COL_GREEN   = 3'd2;
  localparam logic [DATA_W-1:0] COL_CYAN    = 3'd3;
  localparam logic [DATA_W-1:0] COL_RED     = 3'd4;
  localparam logic [DATA_W-1:0] COL_MAGENTA = 3'd5;
  localparam logic [DATA_W-1:0] COL_YELLOW  = 3'd6;
  localparam logic [DATA_W-1:0] COL_WHITE   = 3'd7;

  // Unsigned compare against the pixel count; anything past the last pixel is off-screen.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a < DEPTH_A;
  endfunction

  // Off-screen addresses collapse to entry 0 so the array is never indexed past its end;
  // callers still mask the result with addr_in_range.
  function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] a);
    return addr_in_range(a) ? a[IDX_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/memory_read_port.sv
// One scan-out read port: range check on the address and a single output register.
module mem_read_port
  import memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rd_word,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] rdata_p1;

  assign rd_idx = addr_to_idx(raddr);

  // Stage p1: register the looked-up word; off-screen reads return black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
    end else begin
      rdata_p1 <= addr_in_range(raddr) ? rd_word : '0;
    end
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/memory.sv
// Frame buffer: one 3-bit colour per pixel, one write port, two independent read ports.
// Reads see the array contents before any same-cycle write (read-before-write).
module memory
  import memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  rd_idx1;
  logic [IDX_W-1:0]  rd_idx2;
  logic [DATA_W-1:0] rd_word1;
  logic [DATA_W-1:0] rd_word2;

  // Storage: whole-array clear on reset, otherwise write on-screen addresses only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we && addr_in_range(waddr)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rd_word1 = mem[rd_idx1];
  assign rd_word2 = mem[rd_idx2];

  mem_read_port u_rp1 (
    .clk     (clk),
    .rst     (rst),
    .raddr   (raddr),
    .rd_word (rd_word1),
    .rd_idx  (rd_idx1),
    .rdata   (rdata)
  );

  mem_read_port u_rp2 (
    .clk     (clk),
    .rst     (rst),
    .raddr   (raddr2),
    .rd_word (rd_word2),
    .rd_idx  (rd_idx2),
    .rdata   (rdata2)
  );

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the frame buffer: the driver predicts each read from a
// pixel-array model and queues it; a monitor compares when the read result appears.
module tb_memory;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [15:0] waddr = '0;
  logic [15:0] raddr = '0;
  logic [15:0] raddr2 = '0;
  logic [2:0]  wdata = '0;
  logic [2:0]  rdata;
  logic [2:0]  rdata2;

  logic        chk = 1'b0;
  string       phase = "init";
  int          checks = 0;
  int          errors = 0;

  logic [2:0]  ref_mem [N];
  logic [2:0]  q1 [$];
  logic [2:0]  q2 [$];

  always #5 clk = ~clk;

  memory dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .raddr  (raddr),
    .raddr2 (raddr2),
    .wdata  (wdata),
    .rdata  (rdata),
    .rdata2 (rdata2)
  );

  function automatic logic [2:0] ref_read(input logic [15:0] a);
    if (int'(a) < N) return ref_mem[int'(a)];
    return 3'd0;
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 16'($urandom_range(N, 65535));
    return 16'($urandom_range(0, N - 1));
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model applies the write after predicting the reads.
  task automatic cyc(input logic w, input logic [15:0] wa, input logic [2:0] wd,
                     input logic [15:0] ra, input logic [15:0] ra2, input logic c);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; raddr = ra; raddr2 = ra2; chk = c;
    if (c) begin
      q1.push_back(ref_read(ra));
      q2.push_back(ref_read(ra2));
    end
    if (w && int'(wa) < N) ref_mem[int'(wa)] = wd;
  endtask

  // Monitor: a read issued at this edge is visible just after it.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && chk) begin
        #1;
        if (q1.size() == 0 || q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s/queue actual=empty required=entry", phase);
        end else begin
          check({phase, "/rdata"}, rdata, q1.pop_front());
          check({phase, "/rdata2"}, rdata2, q2.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) ref_mem[k] = 3'd0;

    phase = "reset_init";
    #1 rst = 1'b1;
    #1;
    check("reset_init/rdata", rdata, 3'd0);
    check("reset_init/rdata2", rdata2, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    phase = "reset_mid";
    cyc(1'b1, 16'd0, 3'b101, 16'd0, 16'd0, 1'b0);
    cyc(1'b1, 16'(N - 1), 3'b101, 16'd0, 16'd0, 1'b0);
    cyc(1'b0, 16'd0, 3'd0, 16'd0, 16'(N - 1), 1'b1);
    cyc(1'b0, 16'd0, 3'd0, 16'd0, 16'(N - 1), 1'b0);
    #2 rst = 1'b1;
    for (int k = 0; k < N; k++) ref_mem[k] = 3'd0;
    #1;
    check("reset_async/rdata", rdata, 3'd0);
    check("reset_async/rdata2", rdata2, 3'd0);
    we = 1'b1; waddr = 16'd0; wdata = 3'd7;
    @(posedge clk);
    #1;
    check("reset_hold/rdata", rdata, 3'd0);
    check("reset_hold/rdata2", rdata2, 3'd0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    phase = "after_reset";
    cyc(1'b0, 16'd0, 3'd0, 16'd0, 16'(N - 1), 1'b1);
    cyc(1'b0, 16'd0, 3'd0, 16'(N - 1), 16'd0, 1'b1);

    phase = "write_read";
    cyc(1'b1, 16'(1 * W + 1), 3'b011, 16'd0, 16'd0, 1'b0);
    cyc(1'b0, 16'd0, 3'd0, 16'(1 * W + 1), 16'(1 * W + 1), 1'b1);

    phase = "collision";
    cyc(1'b1, 16'd500, 3'd2, 16'd0, 16'd0, 1'b0);
    cyc(1'b1, 16'd500, 3'd7, 16'd500, 16'd500, 1'b1);
    cyc(1'b0, 16'd0, 3'd0, 16'd500, 16'd500, 1'b1);

    phase = "bounds";
    cyc(1'b1, 16'(N), 3'd5, 16'd0, 16'd0, 1'b0);
    cyc(1'b1, 16'hFFFF, 3'd5, 16'd0, 16'd0, 1'b0);
    cyc(1'b0, 16'd0, 3'd0, 16'd0, 16'(N - 1), 1'b1);
    cyc(1'b0, 16'd0, 3'd0, 16'(N), 16'hFFFF, 1'b1);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), rand_addr(), 3'($urandom_range(0, 7)),
          rand_addr(), rand_addr(), 1'b1);
    end

    phase = "fill";
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, 16'(k), 3'(k % 8), rand_addr(), rand_addr(), 1'b1);
    end

    phase = "sweep";
    for (int k = 0; k < N; k++) begin
      cyc(1'b0, 16'd0, 3'd0, 16'(k), 16'(N - 1 - k), 1'b1);
    end

    // Clear pass: port 1 trails the write pointer, port 2 collides with it.
    phase = "clear";
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, 16'(k), 3'd0, (k == 0) ? 16'(N - 1) : 16'(k - 1), 16'(k), 1'b1);
    end

    phase = "cleared";
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 16'd0, 3'd0, rand_addr(), rand_addr(), 1'b1);
    end
    cyc(1'b0, 16'd0, 3'd0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);

    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0", q1.size(), q2.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
